// File: rtl/l1d_sa_pkg.sv
// Shared types and default geometry for the set-associative L1 data cache.
package l1d_sa_pkg;

   localparam int L1D_ADDR_WIDTH = 32;
   localparam int L1D_DATA_WIDTH = 32;
   localparam int L1D_LINE_BYTES = 16;
   localparam int L1D_SETS       = 64;
   localparam int L1D_WAYS       = 2;

   // Address field widths for the default geometry; the cache recomputes them from its parameters.
   localparam int OFFSET_BITS   = $clog2(L1D_LINE_BYTES);
   localparam int INDEX_BITS    = $clog2(L1D_SETS);
   localparam int TAG_BITS      = L1D_ADDR_WIDTH - OFFSET_BITS - INDEX_BITS;
   localparam int WORD_SEL_BITS = OFFSET_BITS - $clog2(L1D_DATA_WIDTH / 8);

   typedef logic [2:0] l1d_state_t;
   localparam l1d_state_t ST_IDLE      = 3'd0;
   localparam l1d_state_t ST_COMPARE   = 3'd1;
   localparam l1d_state_t ST_WRITEBACK = 3'd2;
   localparam l1d_state_t ST_REFILL    = 3'd3;
   localparam l1d_state_t ST_RESPOND   = 3'd4;

   typedef struct packed {
      logic                      store;
      logic [TAG_BITS-1:0]       tag;
      logic [INDEX_BITS-1:0]     index;
      logic [WORD_SEL_BITS-1:0]  word_sel;
      logic [L1D_DATA_WIDTH-1:0] wdata;
      logic [L1D_DATA_WIDTH/8-1:0] wstrb;
   } l1d_req_t;

   function automatic int way_bits(input int ways);
      return (ways > 1) ? $clog2(ways) : 1;
   endfunction

endpackage

// File: rtl/l1d_sa_plru.sv
// Per-set tree pseudo-LRU: WAYS-1 bits per set, each bit points at the colder subtree.
module l1d_plru
   import l1d_sa_pkg::*;
#(
   parameter int SETS  = 64,
   parameter int WAYS  = 2,
   parameter int IDX_W = $clog2(SETS),
   parameter int WAY_W = way_bits(WAYS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] index,
   output logic [WAY_W-1:0] victim_way,
   input  logic             touch_en,
   input  logic [IDX_W-1:0] touch_index,
   input  logic [WAY_W-1:0] touch_way
);

   generate
      if (WAYS == 1) begin : g_direct
         logic unused_plru;
         assign unused_plru = ^{clk, rst, index, touch_en, touch_index, touch_way};
         assign victim_way  = '0;
      end else begin : g_tree
         localparam int LEVELS = $clog2(WAYS);
         logic [WAYS-2:0] bits_q [SETS];
         logic [WAYS-2:0] touched;

         // Heap-ordered nodes: node n has children 2n and 2n+1, stored at bit n-1.
         always_comb begin
            int node;
            node = 1;
            for (int l = 0; l < LEVELS; l++) begin
               node = 2 * node + (bits_q[index][node-1] ? 1 : 0);
            end
            victim_way = WAY_W'(node - WAYS);
         end

         always_comb begin
            int tnode;
            touched = bits_q[touch_index];
            tnode   = 1;
            for (int l = 0; l < LEVELS; l++) begin
               touched[tnode-1] = ~touch_way[LEVELS-1-l];
               tnode = 2 * tnode + (touch_way[LEVELS-1-l] ? 1 : 0);
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               for (int s = 0; s < SETS; s++) bits_q[s] <= '0;
            end else if (touch_en) begin
               bits_q[touch_index] <= touched;
            end
         end
      end
   endgenerate

endmodule

// File: rtl/l1d_sa.sv
// N-way set-associative write-back, write-allocate L1 data cache with a line-wide memory port.
module l1d_sa
   import l1d_sa_pkg::*;
#(
   parameter int ADDR_WIDTH = L1D_ADDR_WIDTH,
   parameter int DATA_WIDTH = L1D_DATA_WIDTH,
   parameter int LINE_BYTES = L1D_LINE_BYTES,
   parameter int SETS       = L1D_SETS,
   parameter int WAYS       = L1D_WAYS
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cpu_l1_valid,
   output logic                    cpu_l1_ready,
   input  logic                    cpu_l1_store,
   input  logic [ADDR_WIDTH-1:0]   cpu_l1_addr,
   input  logic [DATA_WIDTH-1:0]   cpu_l1_wdata,
   input  logic [DATA_WIDTH/8-1:0] cpu_l1_wstrb,
   output logic                    l1_cpu_valid,
   output logic [DATA_WIDTH-1:0]   l1_cpu_rdata,
   output logic                    l1_mem_valid,
   input  logic                    l1_mem_ready,
   output logic                    l1_mem_write,
   output logic [ADDR_WIDTH-1:0]   l1_mem_addr,
   output logic [LINE_BYTES*8-1:0] l1_mem_wdata,
   input  logic                    mem_l1_valid,
   input  logic [LINE_BYTES*8-1:0] mem_l1_rdata
);

   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int LINE_W = LINE_BYTES * 8;
   localparam int OFF_W  = $clog2(LINE_BYTES);
   localparam int IDX_W  = $clog2(SETS);
   localparam int TAG_W  = ADDR_WIDTH - OFF_W - IDX_W;
   localparam int BYTE_W = $clog2(STRB_W);
   localparam int WSEL_W = (OFF_W > BYTE_W) ? OFF_W - BYTE_W : 1;
   localparam int WAY_W  = way_bits(WAYS);

   typedef struct packed {
      logic              store;
      logic [TAG_W-1:0]  tag;
      logic [IDX_W-1:0]  index;
      logic [WSEL_W-1:0] word_sel;
      logic [DATA_WIDTH-1:0] wdata;
      logic [STRB_W-1:0] wstrb;
   } req_t;

   l1d_state_t        state_q;
   req_t              req_q;
   logic [WAY_W-1:0]  way_q;
   logic              req_sent_q;

   logic [WAYS-1:0]   valid_q [SETS];
   logic [WAYS-1:0]   dirty_q [SETS];
   logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
   logic [LINE_W-1:0] data_q  [SETS][WAYS];

   logic              hit;
   logic [WAY_W-1:0]  hit_way;
   logic              inv_found;
   logic [WAY_W-1:0]  inv_way;
   logic [WAY_W-1:0]  plru_way;
   logic [WAY_W-1:0]  victim_way;
   logic [LINE_W-1:0] cur_line;
   logic [DATA_WIDTH-1:0] cur_word;
   logic [DATA_WIDTH-1:0] merged;

   always_comb begin
      hit       = 1'b0;
      hit_way   = '0;
      inv_found = 1'b0;
      inv_way   = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[req_q.index][w] && tag_q[req_q.index][w] == req_q.tag && !hit) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
         if (!valid_q[req_q.index][w] && !inv_found) begin
            inv_found = 1'b1;
            inv_way   = WAY_W'(w);
         end
      end
      victim_way = inv_found ? inv_way : plru_way;
   end

   // Loads see merged == cur_word because the store flag gates every byte lane.
   always_comb begin
      cur_line = data_q[req_q.index][way_q];
      cur_word = cur_line[req_q.word_sel*DATA_WIDTH +: DATA_WIDTH];
      merged   = cur_word;
      for (int b = 0; b < STRB_W; b++) begin
         if (req_q.store && req_q.wstrb[b]) merged[b*8 +: 8] = req_q.wdata[b*8 +: 8];
      end
   end

   assign cpu_l1_ready = (state_q == ST_IDLE) && !rst;
   assign l1_cpu_valid = (state_q == ST_RESPOND);
   assign l1_cpu_rdata = (state_q == ST_RESPOND) ? merged : '0;
   assign l1_mem_valid = (state_q == ST_WRITEBACK) || (state_q == ST_REFILL && !req_sent_q);
   assign l1_mem_write = (state_q == ST_WRITEBACK);
   assign l1_mem_wdata = (state_q == ST_WRITEBACK) ? cur_line : '0;

   always_comb begin
      l1_mem_addr = '0;
      if (state_q == ST_WRITEBACK)
         l1_mem_addr = {tag_q[req_q.index][way_q], req_q.index, {OFF_W{1'b0}}};
      else if (state_q == ST_REFILL && !req_sent_q)
         l1_mem_addr = {req_q.tag, req_q.index, {OFF_W{1'b0}}};
   end

   l1d_plru #(
      .SETS  (SETS),
      .WAYS  (WAYS),
      .IDX_W (IDX_W),
      .WAY_W (WAY_W)
   ) u_plru (
      .clk         (clk),
      .rst         (rst),
      .index       (req_q.index),
      .victim_way  (plru_way),
      .touch_en    (state_q == ST_RESPOND),
      .touch_index (req_q.index),
      .touch_way   (way_q)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         req_sent_q <= 1'b0;
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            dirty_q[s] <= '0;
         end
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (cpu_l1_valid) begin
                  req_q.store    <= cpu_l1_store;
                  req_q.tag      <= cpu_l1_addr[ADDR_WIDTH-1 -: TAG_W];
                  req_q.index    <= cpu_l1_addr[OFF_W +: IDX_W];
                  req_q.word_sel <= WSEL_W'(cpu_l1_addr[OFF_W-1:0] >> BYTE_W);
                  req_q.wdata    <= cpu_l1_wdata;
                  req_q.wstrb    <= cpu_l1_wstrb;
                  state_q        <= ST_COMPARE;
               end
            end
            ST_COMPARE: begin
               req_sent_q <= 1'b0;
               if (hit) begin
                  way_q   <= hit_way;
                  state_q <= ST_RESPOND;
               end else begin
                  way_q <= victim_way;
                  if (valid_q[req_q.index][victim_way] && dirty_q[req_q.index][victim_way])
                     state_q <= ST_WRITEBACK;
                  else
                     state_q <= ST_REFILL;
               end
            end
            ST_WRITEBACK: begin
               if (l1_mem_ready) state_q <= ST_REFILL;
            end
            ST_REFILL: begin
               // First the read request handshake, then wait for the returning line.
               if (!req_sent_q) begin
                  if (l1_mem_ready) req_sent_q <= 1'b1;
               end else if (mem_l1_valid) begin
                  data_q[req_q.index][way_q]  <= mem_l1_rdata;
                  tag_q[req_q.index][way_q]   <= req_q.tag;
                  valid_q[req_q.index][way_q] <= 1'b1;
                  dirty_q[req_q.index][way_q] <= 1'b0;
                  state_q                     <= ST_RESPOND;
               end
            end
            ST_RESPOND: begin
               if (req_q.store) begin
                  data_q[req_q.index][way_q][req_q.word_sel*DATA_WIDTH +: DATA_WIDTH] <= merged;
                  if (|req_q.wstrb) dirty_q[req_q.index][way_q] <= 1'b1;
               end
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_l1d_sa.sv
// Bench for l1d_sa: flat golden memory plus an LRU occupancy model predicting data and memory traffic.
module tb_l1d_sa;

   localparam int NSETS  = 64;
   localparam int NWAYS  = 2;
   localparam int LW     = 128;
   localparam int NLINES = 256;

   logic          clk = 1'b0;
   logic          rst;
   logic          cpu_l1_valid, cpu_l1_ready, cpu_l1_store;
   logic [31:0]   cpu_l1_addr, cpu_l1_wdata;
   logic [3:0]    cpu_l1_wstrb;
   logic          l1_cpu_valid;
   logic [31:0]   l1_cpu_rdata;
   logic          l1_mem_valid, l1_mem_ready, l1_mem_write;
   logic [31:0]   l1_mem_addr;
   logic [LW-1:0] l1_mem_wdata;
   logic          mem_l1_valid;
   logic [LW-1:0] mem_l1_rdata;

   always #5 clk = ~clk;

   l1d_sa dut (
      .clk          (clk),
      .rst          (rst),
      .cpu_l1_valid (cpu_l1_valid),
      .cpu_l1_ready (cpu_l1_ready),
      .cpu_l1_store (cpu_l1_store),
      .cpu_l1_addr  (cpu_l1_addr),
      .cpu_l1_wdata (cpu_l1_wdata),
      .cpu_l1_wstrb (cpu_l1_wstrb),
      .l1_cpu_valid (l1_cpu_valid),
      .l1_cpu_rdata (l1_cpu_rdata),
      .l1_mem_valid (l1_mem_valid),
      .l1_mem_ready (l1_mem_ready),
      .l1_mem_write (l1_mem_write),
      .l1_mem_addr  (l1_mem_addr),
      .l1_mem_wdata (l1_mem_wdata),
      .mem_l1_valid (mem_l1_valid),
      .mem_l1_rdata (mem_l1_rdata)
   );

   int checks   = 0;
   int failures = 0;

   logic [LW-1:0] mem_lines  [NLINES];
   logic [LW-1:0] gold_lines [NLINES];

   logic          m_valid [NSETS][NWAYS];
   logic          m_dirty [NSETS][NWAYS];
   logic [21:0]   m_tag   [NSETS][NWAYS];
   int            m_last  [NSETS][NWAYS];
   int            m_time;

   int            stall_left = 0;
   int            mem_lat    = 0;
   logic          spurious   = 1'b0;
   logic          pend       = 1'b0;
   int            resp_cnt   = 0;
   int            pend_line  = 0;

   logic [32:0]   obs_q[$];
   logic [LW-1:0] obs_wd_q[$];
   logic [32:0]   exp_q[$];
   logic [LW-1:0] exp_wd_q[$];

   logic [31:0]   last_rdata;
   int            last_lat;
   int            last_wb_cycles;

   // Next-level memory: answers requests from its own process, records every accepted request.
   initial begin
      l1_mem_ready = 1'b0;
      mem_l1_valid = 1'b0;
      mem_l1_rdata = '0;
      forever begin
         @(negedge clk);
         mem_l1_valid = 1'b0;
         if (pend) begin
            if (resp_cnt == 0) begin
               mem_l1_valid = 1'b1;
               mem_l1_rdata = mem_lines[pend_line];
               pend = 1'b0;
            end else begin
               resp_cnt--;
            end
         end
         if (spurious) begin
            mem_l1_valid = 1'b1;
            mem_l1_rdata = {$urandom, $urandom, $urandom, $urandom};
            spurious = 1'b0;
         end
         if (l1_mem_valid) begin
            if (stall_left > 0) begin
               l1_mem_ready = 1'b0;
               stall_left--;
            end else begin
               l1_mem_ready = 1'b1;
               obs_q.push_back({l1_mem_write, l1_mem_addr});
               if (l1_mem_write) begin
                  obs_wd_q.push_back(l1_mem_wdata);
                  mem_lines[(l1_mem_addr >> 4) & 32'hFF] = l1_mem_wdata;
               end else begin
                  pend      = 1'b1;
                  resp_cnt  = mem_lat;
                  pend_line = int'((l1_mem_addr >> 4) & 32'hFF);
               end
            end
         end else begin
            l1_mem_ready = 1'b0;
         end
      end
   end

   task automatic model_reset();
      for (int s = 0; s < NSETS; s++) begin
         for (int w = 0; w < NWAYS; w++) begin
            m_valid[s][w] = 1'b0;
            m_dirty[s][w] = 1'b0;
            m_last[s][w]  = 0;
         end
      end
      for (int l = 0; l < NLINES; l++) gold_lines[l] = mem_lines[l];
      m_time = 0;
   endtask

   task automatic do_access(input logic st, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [3:0] ws);
      int set, line, word, hw, vw, waited, cyc;
      logic [21:0] tg;
      logic [31:0] exp_rd, wb_addr;
      logic [LW-1:0] wb_data;
      logic hit, got, has_wb;
      set  = int'(addr[9:4]);
      tg   = addr[31:10];
      line = int'(addr[11:4]);
      word = int'(addr[3:2]);
      hit = 1'b0;
      hw  = 0;
      exp_q.delete();
      exp_wd_q.delete();
      has_wb  = 1'b0;
      wb_addr = '0;
      wb_data = '0;
      for (int w = 0; w < NWAYS; w++)
         if (m_valid[set][w] && m_tag[set][w] == tg) begin hit = 1'b1; hw = w; end
      if (!hit) begin
         vw = -1;
         for (int w = 0; w < NWAYS; w++) if (!m_valid[set][w] && vw < 0) vw = w;
         if (vw < 0) begin
            vw = 0;
            for (int w = 1; w < NWAYS; w++) if (m_last[set][w] < m_last[set][vw]) vw = w;
         end
         if (m_valid[set][vw] && m_dirty[set][vw]) begin
            has_wb  = 1'b1;
            wb_addr = {m_tag[set][vw], 6'(set), 4'h0};
            wb_data = gold_lines[int'(wb_addr[11:4])];
            exp_q.push_back({1'b1, wb_addr});
            exp_wd_q.push_back(wb_data);
         end
         exp_q.push_back({1'b0, addr & 32'hFFFF_FFF0});
         m_valid[set][vw] = 1'b1;
         m_dirty[set][vw] = 1'b0;
         m_tag[set][vw]   = tg;
         hw = vw;
      end
      exp_rd = gold_lines[line][word*32 +: 32];
      if (st) begin
         for (int b = 0; b < 4; b++) if (ws[b]) exp_rd[b*8 +: 8] = wd[b*8 +: 8];
         gold_lines[line][word*32 +: 32] = exp_rd;
         if (ws != 4'b0000) m_dirty[set][hw] = 1'b1;
      end
      m_time++;
      m_last[set][hw] = m_time;

      obs_q.delete();
      obs_wd_q.delete();
      @(negedge clk);
      cpu_l1_valid = 1'b1;
      cpu_l1_store = st;
      cpu_l1_addr  = addr;
      cpu_l1_wdata = wd;
      cpu_l1_wstrb = ws;
      waited = 0;
      while (!cpu_l1_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      checks++;
      if (cpu_l1_ready !== 1'b1) begin
         failures++;
         $display("FAIL accept_timeout addr=%h ready=%b required=1", addr, cpu_l1_ready);
      end
      @(negedge clk);
      cpu_l1_valid = 1'b0;
      cpu_l1_store = 1'($urandom);
      cpu_l1_addr  = $urandom;
      cpu_l1_wdata = $urandom;
      cpu_l1_wstrb = 4'($urandom);
      got = 1'b0;
      last_lat = 0;
      last_wb_cycles = 0;
      for (cyc = 1; cyc <= 300; cyc++) begin
         if (cyc > 1) @(negedge clk);
         if (l1_cpu_valid === 1'b1) begin
            got = 1'b1;
            last_lat = cyc;
            last_rdata = l1_cpu_rdata;
            break;
         end
         checks++;
         if (cpu_l1_ready !== 1'b0) begin
            failures++;
            $display("FAIL busy_ready addr=%h cycle=%0d ready=%b required=0", addr, cyc, cpu_l1_ready);
         end
         if (l1_mem_valid === 1'b1 && l1_mem_write === 1'b1) begin
            last_wb_cycles++;
            checks++;
            if (!has_wb || l1_mem_addr !== wb_addr || l1_mem_wdata !== wb_data) begin
               failures++;
               $display("FAIL wb_drive addr=%h got=%h/%h required=%h/%h expected_wb=%b",
                        addr, l1_mem_addr, l1_mem_wdata, wb_addr, wb_data, has_wb);
            end
         end
      end
      checks++;
      if (!got) begin
         failures++;
         $display("FAIL resp_timeout addr=%h no response within 300 cycles", addr);
      end else begin
         checks++;
         if (last_rdata !== exp_rd) begin
            failures++;
            $display("FAIL rdata addr=%h store=%b got=%h required=%h", addr, st, last_rdata, exp_rd);
         end
         if (hit) begin
            checks++;
            if (last_lat != 2) begin
               failures++;
               $display("FAIL hit_latency addr=%h got=%0d required=2", addr, last_lat);
            end
         end
      end
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         failures++;
         $display("FAIL mem_traffic_count addr=%h got=%0d required=%0d", addr, obs_q.size(), exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            if (obs_q[i] !== exp_q[i]) begin
               failures++;
               $display("FAIL mem_traffic addr=%h entry=%0d got=%h required=%h", addr, i, obs_q[i], exp_q[i]);
            end
         end
         if (obs_wd_q.size() == exp_wd_q.size()) begin
            for (int i = 0; i < exp_wd_q.size(); i++) begin
               if (obs_wd_q[i] !== exp_wd_q[i]) begin
                  failures++;
                  $display("FAIL wb_data addr=%h got=%h required=%h", addr, obs_wd_q[i], exp_wd_q[i]);
               end
            end
         end
      end
      @(negedge clk);
      checks++;
      if (l1_cpu_valid !== 1'b0 || cpu_l1_ready !== 1'b1) begin
         failures++;
         $display("FAIL resp_pulse addr=%h valid=%b ready=%b required=0/1", addr, l1_cpu_valid, cpu_l1_ready);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cpu_l1_valid = 1'b0;
      cpu_l1_store = 1'b0;
      cpu_l1_addr  = '0;
      cpu_l1_wdata = '0;
      cpu_l1_wstrb = '0;
      repeat (2) @(negedge clk);
      checks++;
      if (cpu_l1_ready !== 1'b0) begin
         failures++;
         $display("FAIL reset_ready_low got=%b required=0", cpu_l1_ready);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (cpu_l1_ready !== 1'b1 || l1_cpu_valid !== 1'b0 || l1_cpu_rdata !== 32'h0 ||
          l1_mem_valid !== 1'b0 || l1_mem_write !== 1'b0 || l1_mem_addr !== 32'h0 ||
          l1_mem_wdata !== '0) begin
         failures++;
         $display("FAIL reset_outputs got ready=%b cv=%b rd=%h mv=%b mw=%b ma=%h required 1/0/0/0/0/0",
                  cpu_l1_ready, l1_cpu_valid, l1_cpu_rdata, l1_mem_valid, l1_mem_write, l1_mem_addr);
      end
      model_reset();
   endtask

   task automatic test_load_miss_hit();
      do_access(1'b0, 32'h000, 32'h0, 4'h0);
      checks++;
      if (last_rdata !== 32'hAAAA0001 || last_lat <= 2) begin
         failures++;
         $display("FAIL first_load got=%h lat=%0d required=aaaa0001 lat>2", last_rdata, last_lat);
      end
      do_access(1'b0, 32'h000, 32'h0, 4'h0);
      checks++;
      if (last_lat != 2 || obs_q.size() != 0) begin
         failures++;
         $display("FAIL repeat_load_hit lat=%0d mem_reqs=%0d required 2/0", last_lat, obs_q.size());
      end
   endtask

   task automatic test_store_merge();
      do_access(1'b1, 32'h004, 32'h11223344, 4'b0011);
      checks++;
      if (last_rdata !== 32'hDEAD3344) begin
         failures++;
         $display("FAIL store_merge got=%h required=dead3344", last_rdata);
      end
   endtask

   task automatic test_evict_stall();
      do_access(1'b0, 32'h400, 32'h0, 4'h0);
      do_access(1'b0, 32'h400, 32'h0, 4'h0);
      stall_left = 5;
      do_access(1'b0, 32'h800, 32'h0, 4'h0);
      checks++;
      if (last_wb_cycles != 6 || obs_q.size() != 2) begin
         failures++;
         $display("FAIL wb_stall wb_cycles=%0d mem_reqs=%0d required 6/2", last_wb_cycles, obs_q.size());
      end
      do_access(1'b0, 32'h000, 32'h0, 4'h0);
      checks++;
      if (last_lat <= 2) begin
         failures++;
         $display("FAIL evicted_reaccess lat=%0d required>2", last_lat);
      end
   endtask

   task automatic test_reset_refill();
      int waited;
      mem_lat = 8;
      @(negedge clk);
      cpu_l1_valid = 1'b1;
      cpu_l1_store = 1'b0;
      cpu_l1_addr  = 32'h020;
      obs_q.delete();
      @(negedge clk);
      cpu_l1_valid = 1'b0;
      waited = 0;
      while (obs_q.size() == 0 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      checks++;
      if (obs_q.size() != 1) begin
         failures++;
         $display("FAIL refill_request_seen got=%0d required=1", obs_q.size());
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (l1_mem_valid !== 1'b0 || cpu_l1_ready !== 1'b1 || l1_cpu_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_refill mv=%b ready=%b cv=%b required 0/1/0",
                  l1_mem_valid, cpu_l1_ready, l1_cpu_valid);
      end
      model_reset();
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         checks++;
         if (l1_cpu_valid !== 1'b0 || l1_mem_valid !== 1'b0) begin
            failures++;
            $display("FAIL late_refill_ignored cycle=%0d cv=%b mv=%b required 0/0", i, l1_cpu_valid, l1_mem_valid);
         end
      end
      mem_lat = 0;
      do_access(1'b0, 32'h000, 32'h0, 4'h0);
      checks++;
      if (last_lat <= 2) begin
         failures++;
         $display("FAIL invalid_after_reset lat=%0d required>2", last_lat);
      end
   endtask

   task automatic test_spurious();
      @(negedge clk);
      spurious = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (l1_cpu_valid !== 1'b0 || l1_mem_valid !== 1'b0) begin
            failures++;
            $display("FAIL spurious_refill cycle=%0d cv=%b mv=%b required 0/0", i, l1_cpu_valid, l1_mem_valid);
         end
      end
      do_access(1'b0, 32'h000, 32'h0, 4'h0);
   endtask

   task automatic test_zero_strobe();
      do_access(1'b1, 32'h010, $urandom, 4'b0000);
      do_access(1'b0, 32'h410, 32'h0, 4'h0);
      do_access(1'b0, 32'h810, 32'h0, 4'h0);
      checks++;
      if (obs_q.size() != 1) begin
         failures++;
         $display("FAIL zero_strobe_clean mem_reqs=%0d required=1", obs_q.size());
      end
   endtask

   task automatic test_random();
      logic [31:0] a;
      for (int n = 0; n < 150; n++) begin
         a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 4) |
             (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
         stall_left = $urandom_range(0, 3);
         mem_lat    = $urandom_range(0, 4);
         do_access(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
      end
      stall_left = 0;
      mem_lat    = 0;
   endtask

   initial begin
      for (int l = 0; l < NLINES; l++) mem_lines[l] = {$urandom, $urandom, $urandom, $urandom};
      mem_lines[0][31:0]  = 32'hAAAA0001;
      mem_lines[0][63:32] = 32'hDEADBEEF;
      test_reset();
      test_load_miss_hit();
      test_store_merge();
      test_evict_stall();
      test_reset_refill();
      test_spurious();
      test_zero_strobe();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
